// File: rtl/spi_word_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_word_rx: SPI mode-0 word receiver, 2-flop input sync, valid/ready out |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module spi_word_rx #(
   parameter int WIDTH         = 32,
   parameter bit CS_ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             spi_sck,
   input  logic             spi_mosi,
   input  logic             spi_cs,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   output logic             frame_err
);
   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [1:0]       IDLE     = 2'd0;
   localparam logic [1:0]       SHIFT    = 2'd1;
   localparam logic [1:0]       TAIL     = 2'd2;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic             sck_meta_q, sck_sync_q, sck_prev_q;
   logic             mosi_meta_q, mosi_sync_q;
   logic             cs_meta_q, cs_sync_q;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             extra_q, extra_d;
   logic             armed_q, armed_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             overflow_q, overflow_d;
   logic             frame_err_q, frame_err_d;
   logic             cs_act;
   logic             sck_rise;
   logic             word_done;

   assign cs_act   = CS_ACTIVE_LOW ? ~cs_sync_q : cs_sync_q;
   assign sck_rise = sck_sync_q & ~sck_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_meta_q  <= 1'b0;
         sck_sync_q  <= 1'b0;
         sck_prev_q  <= 1'b0;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
         cs_meta_q   <= 1'b0;
         cs_sync_q   <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         extra_q     <= 1'b0;
         armed_q     <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sck_meta_q  <= spi_sck;
         sck_sync_q  <= sck_meta_q;
         sck_prev_q  <= sck_sync_q;
         mosi_meta_q <= spi_mosi;
         mosi_sync_q <= mosi_meta_q;
         cs_meta_q   <= spi_cs;
         cs_sync_q   <= cs_meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         extra_q     <= extra_d;
         armed_q     <= armed_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   // A frame may only start once cs has been seen deasserted, so a frame
   // that was already running when reset released is skipped entirely.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_act && armed_q) state_d = SHIFT;
         SHIFT: begin
            if (!cs_act)                           state_d = IDLE;
            else if (sck_rise && cnt_q == LAST_BIT) state_d = TAIL;
         end
         TAIL:    if (!cs_act) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      extra_d     = extra_q;
      armed_d     = armed_q | ~cs_act;
      word_done   = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            extra_d = 1'b0;
         end
         SHIFT: begin
            if (!cs_act) begin
               frame_err_d = 1'b1;
               cnt_d       = '0;
            end else if (sck_rise) begin
               shift_d    = shift_q << 1;
               shift_d[0] = mosi_sync_q;
               cnt_d      = cnt_q + CNT_W'(1);
               word_done  = (cnt_q == LAST_BIT);
            end
         end
         TAIL: begin
            if (!cs_act) begin
               frame_err_d = extra_q;
               extra_d     = 1'b0;
            end else if (sck_rise) begin
               extra_d = 1'b1;
            end
         end
         default: ;
      endcase

      // Output slot frees on a handshake, which lets a completing word
      // replace the departing one on the same edge.
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q & ~out_ready;
      overflow_d  = 1'b0;
      if (word_done) begin
         if (!out_valid_q || out_ready) begin
            out_data_d  = shift_d;
            out_valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

endmodule
`default_nettype wire
